// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder: width derivation
// and a ceiling-log2 for callers that need counter widths.
package cla_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic int ngroups(input int width, input int stages, input int block);
    return (width / stages) / block;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result stream bundle for the pipelined CLA adder; the adder is the
// slave (consumes operands, produces results).
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_group.sv
// Combinational BLOCK-bit carry-lookahead group: every internal carry is a
// flat sum of generate/propagate products, plus group G/P for the next level.
module cla_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             cin_i,
  output logic [BLOCK-1:0] sum_o,
  output logic             g_o,
  output logic             p_o
);
  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    logic acc;
    acc = 1'b0;
    c   = '0;
    g_o = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      acc = cin_i;
      for (int m = 0; m < i; m++) acc = acc & p[m];
      c[i] = acc;
      for (int j = 0; j < i; j++) begin
        acc = g[j];
        for (int m = j + 1; m < i; m++) acc = acc & p[m];
        c[i] = c[i] | acc;
      end
    end
    for (int j = 0; j < BLOCK; j++) begin
      acc = g[j];
      for (int m = j + 1; m < BLOCK; m++) acc = acc & p[m];
      g_o = g_o | acc;
    end
  end

  assign p_o   = &p;
  assign sum_o = p ^ c;
endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: one SLICE-bit lookahead slice per stage,
// carry and high operand bits skewed forward, valid/ready with bubble collapse.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int BLOCK  = 4
) (
  input logic                 clk,
  input logic                 rst,
  pipelined_cla_adder_if.slave bus
);
  localparam int SLICE = slice_w(WIDTH, STAGES);
  localparam int NG    = ngroups(WIDTH, STAGES, BLOCK);

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             ovf;
    logic             zero;
  } stage_t;

  stage_t            st_q [STAGES];
  stage_t            st_d [STAGES];
  logic [STAGES-1:0] free;

  // A stage may load when it is empty or its content moves on this edge.
  always_comb begin
    free = '0;
    free[STAGES-1] = !st_q[STAGES-1].vld || bus.out_ready;
    for (int k = STAGES - 2; k >= 0; k--) free[k] = !st_q[k].vld || free[k+1];
  end

  assign bus.in_ready = free[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [WIDTH-1:0] xa, xb, psum, nsum;
    logic             xc, sv, novf, nzero;
    logic [SLICE-1:0] sa, sb, ss;
    logic [NG-1:0]    gg, gp;
    logic [NG:0]      gc;

    if (k == 0) begin : g_src
      // b is inverted once at accept; later slices see the skewed copy.
      assign xa   = bus.a;
      assign xb   = bus.sub ? ~bus.b : bus.b;
      assign xc   = bus.sub | bus.cin;
      assign psum = '0;
      assign sv   = bus.in_valid;
    end else begin : g_src
      assign xa   = st_q[k-1].a;
      assign xb   = st_q[k-1].b;
      assign xc   = st_q[k-1].c;
      assign psum = st_q[k-1].sum;
      assign sv   = st_q[k-1].vld;
    end

    assign sa = xa[k*SLICE +: SLICE];
    assign sb = xb[k*SLICE +: SLICE];

    always_comb begin
      logic acc;
      acc = 1'b0;
      gc  = '0;
      for (int j = 0; j <= NG; j++) begin
        acc = xc;
        for (int m = 0; m < j; m++) acc = acc & gp[m];
        gc[j] = acc;
        for (int i = 0; i < j; i++) begin
          acc = gg[i];
          for (int m = i + 1; m < j; m++) acc = acc & gp[m];
          gc[j] = gc[j] | acc;
        end
      end
    end

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group #(.BLOCK(BLOCK)) u_grp (
        .a_i   (sa[j*BLOCK +: BLOCK]),
        .b_i   (sb[j*BLOCK +: BLOCK]),
        .cin_i (gc[j]),
        .sum_o (ss[j*BLOCK +: BLOCK]),
        .g_o   (gg[j]),
        .p_o   (gp[j])
      );
    end

    always_comb begin
      nsum = psum;
      nsum[k*SLICE +: SLICE] = ss;
    end

    // Carry into the slice MSB is recovered from its sum bit; only the last
    // stage's flags reach the outputs.
    assign novf  = (sa[SLICE-1] ^ sb[SLICE-1] ^ ss[SLICE-1]) ^ gc[NG];
    assign nzero = ~|nsum;

    assign st_d[k] = '{vld: sv, sum: nsum, a: xa, b: xb, c: gc[NG], ovf: novf, zero: nzero};
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (rst) begin
        st_q[k] <= '0;
      end else if (free[k]) begin
        st_q[k].vld <= st_d[k].vld;
        if (st_d[k].vld) st_q[k] <= st_d[k];
      end
    end
  end

  assign bus.out_valid = st_q[STAGES-1].vld;
  assign bus.sum       = st_q[STAGES-1].sum;
  assign bus.cout      = st_q[STAGES-1].c;
  assign bus.ovf       = st_q[STAGES-1].ovf;
  assign bus.zero      = st_q[STAGES-1].zero;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and streaming checks for the pipelined CLA adder at 32/2/4 and
// 64/4/8 configurations.
module tb_pipelined_cla_adder;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(32)) n_if ();
  pipelined_cla_adder_if #(.WIDTH(64)) w_if ();

  pipelined_cla_adder #(.WIDTH(32), .STAGES(2), .BLOCK(4)) u_n (
    .clk (clk),
    .rst (rst),
    .bus (n_if.slave)
  );

  pipelined_cla_adder #(.WIDTH(64), .STAGES(4), .BLOCK(8)) u_w (
    .clk (clk),
    .rst (rst),
    .bus (w_if.slave)
  );

  function automatic logic [34:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
    logic [31:0] be;
    logic [32:0] r;
    logic        ov;
    be = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, be} + {32'd0, (sub ? 1'b1 : cin)};
    ov = (a[31] == be[31]) && (r[31] != a[31]);
    return {r[31:0], r[32], ov, (r[31:0] == 32'd0)};
  endfunction

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, output logic [31:0] s, output logic [2:0] fl,
                         output int lat);
    n_if.a = a; n_if.b = b; n_if.cin = cin; n_if.sub = sub;
    n_if.in_valid = 1'b1; n_if.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    n_if.in_valid = 1'b0;
    lat = 1;
    while (!n_if.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s  = n_if.sum;
    fl = {n_if.cout, n_if.ovf, n_if.zero};
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    n_if.in_valid = 1'b0; n_if.out_ready = 1'b0;
    w_if.in_valid = 1'b0; w_if.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (n_if.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", n_if.out_valid); end
    total++; if (n_if.sum !== 32'd0) begin bad++; $display("FAIL reset_sum: got %h want 0", n_if.sum); end
    total++; if ({n_if.cout, n_if.ovf, n_if.zero} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {n_if.cout, n_if.ovf, n_if.zero}); end
    rst = 1'b0;
    #1;
    total++; if (n_if.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", n_if.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_arith();
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic        tc [5];
    logic        ts [5];
    logic [31:0] es [5];
    logic [2:0]  ef [5];
    logic [31:0] s;
    logic [2:0]  fl;
    int          lat;
    ta = '{32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000005, 32'h80000000};
    tb = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000007, 32'h00000001};
    tc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    es = '{32'h00000002, 32'h00000000, 32'h80000000, 32'hFFFFFFFE, 32'h7FFFFFFF};
    // flags are {cout, ovf, zero}
    ef = '{3'b000, 3'b101, 3'b010, 3'b000, 3'b110};
    for (int i = 0; i < 5; i++) begin
      run_one(ta[i], tb[i], tc[i], ts[i], s, fl, lat);
      total++; if (s !== es[i]) begin bad++; $display("FAIL arith_sum[%0d]: got %h want %h", i, s, es[i]); end
      total++; if (fl !== ef[i]) begin bad++; $display("FAIL arith_flags[%0d]: got %b want %b", i, fl, ef[i]); end
      total++; if (lat !== 2) begin bad++; $display("FAIL arith_latency[%0d]: got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_stream();
    logic [34:0] exp_q [$];
    logic [34:0] obs, held, e;
    logic [31:0] ca, cb;
    logic        ccin, csub, stalled, want_rdy;
    int          sent, got, cyc, occ;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
    ca = $urandom; cb = $urandom; ccin = 1'($urandom_range(0, 1)); csub = ($urandom_range(0, 3) == 0);
    while (got < 50 && cyc < 3000) begin
      n_if.out_ready = ($urandom_range(0, 3) != 0);
      n_if.in_valid  = (sent < 50);
      n_if.a = ca; n_if.b = cb; n_if.cin = ccin; n_if.sub = csub;
      #1;
      obs = {n_if.sum, n_if.cout, n_if.ovf, n_if.zero};
      occ = sent - got;
      if (stalled) begin
        total++;
        if (!n_if.out_valid || obs !== held) begin bad++; $display("FAIL stream_hold: got v=%b %h want v=1 %h", n_if.out_valid, obs, held); end
      end
      want_rdy = !(occ == 2 && n_if.out_valid && !n_if.out_ready);
      total++; if (n_if.in_ready !== want_rdy) begin bad++; $display("FAIL stream_in_ready: got %b want %b occ=%0d", n_if.in_ready, want_rdy, occ); end
      if (n_if.out_valid && n_if.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL stream_extra: got %h want none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin bad++; $display("FAIL stream_data[%0d]: got %h want %h", got, obs, e); end
        end
        got++;
      end
      stalled = n_if.out_valid && !n_if.out_ready;
      held = obs;
      if (n_if.in_valid && n_if.in_ready) begin
        exp_q.push_back(model32(ca, cb, ccin, csub));
        sent++;
        ca = $urandom; cb = $urandom; ccin = 1'($urandom_range(0, 1)); csub = ($urandom_range(0, 3) == 0);
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    n_if.in_valid = 1'b0; n_if.out_ready = 1'b1;
    total++; if (got != 50 || exp_q.size() != 0) begin bad++; $display("FAIL stream_count: got %0d left %0d want 50 left 0", got, exp_q.size()); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_inflight();
    logic        seen;
    logic [31:0] s;
    logic [2:0]  fl;
    int          lat;
    n_if.out_ready = 1'b1; n_if.sub = 1'b0; n_if.cin = 1'b0;
    n_if.in_valid = 1'b1; n_if.a = 32'd1; n_if.b = 32'd2;
    @(posedge clk); @(negedge clk);
    n_if.a = 32'd3; n_if.b = 32'd4;
    @(posedge clk); @(negedge clk);
    n_if.in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    total++; if (n_if.out_valid !== 1'b0) begin bad++; $display("FAIL rst_flight_valid: got %b want 0", n_if.out_valid); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (n_if.out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_flight_ghost: got %b want 0", seen); end
    run_one(32'd10, 32'd20, 1'b0, 1'b0, s, fl, lat);
    total++; if (s !== 32'd30) begin bad++; $display("FAIL rst_after_sum: got %h want %h", s, 32'd30); end
    total++; if (lat !== 2) begin bad++; $display("FAIL rst_after_latency: got %0d want 2", lat); end
  endtask

  task automatic test_wide();
    logic [63:0] wa [4];
    logic [63:0] wb [4];
    logic        wc [4];
    logic        ws [4];
    logic [66:0] we [4];
    logic [66:0] obs;
    int          i, got;
    wa = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 64'h7FFFFFFFFFFFFFFF, 64'h00000000FFFFFFFF};
    wb = '{64'h0000000000000001, 64'h0000000000000001, 64'h0000000000000000, 64'h0000000000000001};
    wc = '{1'b1, 1'b0, 1'b1, 1'b0};
    ws = '{1'b0, 1'b1, 1'b0, 1'b0};
    // {sum, cout, ovf, zero}
    we = '{{64'h0000000000000001, 3'b100}, {64'hFFFFFFFFFFFFFFFF, 3'b000},
           {64'h8000000000000000, 3'b010}, {64'h0000000100000000, 3'b000}};
    i = 0; got = 0;
    w_if.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      w_if.in_valid = (i < 4);
      if (i < 4) begin
        w_if.a = wa[i]; w_if.b = wb[i]; w_if.cin = wc[i]; w_if.sub = ws[i];
      end
      #1;
      if (w_if.out_valid) begin
        obs = {w_if.sum, w_if.cout, w_if.ovf, w_if.zero};
        total++; if (obs !== we[got]) begin bad++; $display("FAIL wide_data[%0d]: got %h want %h", got, obs, we[got]); end
        total++; if (cyc !== 4 + got) begin bad++; $display("FAIL wide_cycle[%0d]: got %0d want %0d", got, cyc, 4 + got); end
        got++;
      end
      if (w_if.in_valid && w_if.in_ready) i++;
      @(posedge clk); @(negedge clk);
    end
    w_if.in_valid = 1'b0;
    total++; if (got !== 4) begin bad++; $display("FAIL wide_count: got %0d want 4", got); end
  endtask

  initial begin
    rst = 1'b1;
    n_if.in_valid = 1'b0; n_if.out_ready = 1'b0; n_if.a = '0; n_if.b = '0; n_if.cin = 1'b0; n_if.sub = 1'b0;
    w_if.in_valid = 1'b0; w_if.out_ready = 1'b1; w_if.a = '0; w_if.b = '0; w_if.cin = 1'b0; w_if.sub = 1'b0;
    test_reset();
    test_arith();
    test_stream();
    test_reset_inflight();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 32-bit combinational modified-CLA adder.
- The operand width is split into STAGES slices. Each slice is summed by a CLA built from BLOCK-bit groups, and its carry is registered into the next stage.
- Valid/ready handshakes on both sides let it sit in streaming datapaths (ALU back-ends, accumulators) with backpressure.

Parameters:
- WIDTH, 32, operand/sum width in bits.
- STAGES, 2, pipeline stages; latency in cycles. WIDTH % STAGES == 0.
- BLOCK, 4, CLA group size in bits. (WIDTH/STAGES) % BLOCK == 0.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in; ignored when sub=1
- sub  in  1  0: a+b+cin; 1: a-b (a + ~b + 1)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB; for sub, 1 = no borrow
- ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB)
- zero  out  1  sum == 0

Behaviour:
- Clock, reset and handshake
  - One clock. Reset is synchronous and active-high.
  - On rst: all stage valid bits clear. out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - in_ready is combinational: in_ready = !v[0] || adv[0].
  - A beat is accepted when in_valid && in_ready.
  - Reset mid-operation drops every in-flight beat. No result for them ever appears.
- Slicing
  - SLICE = WIDTH/STAGES.
  - Stage k (0..STAGES-1) registers sum bits [k*SLICE +: SLICE] and the carry out of that slice.
  - Stage k's carry-in is stage k-1's registered carry. Stage 0 uses cin, or 1 when sub=1.
  - Operand bits for higher slices travel forward in the stage registers (skew). b is inverted at accept when sub=1.
  - Stage k also forwards the already-computed lower sum bits.
- Pipeline advance
  - Stage k advances when !v[k+1] || adv[k+1]. The last stage advances when !out_valid || out_ready.
  - Bubbles collapse: an empty stage always accepts.
- Timing
  - Latency: a beat accepted at edge N has out_valid=1 after edge N+STAGES, provided there is no backpressure.
  - Throughput: 1 beat/cycle while out_ready=1.
- Output stall
  - While out_valid && !out_ready, sum/cout/ovf/zero hold stable.
  - Upstream stages fill, then in_ready deasserts. No beat is lost or duplicated.
- Flags
  - ovf and zero are computed in the final stage from the full sum and the MSB carries.
  - For sub: cout = !borrow. ovf flags a signed a-b overflow.
- Wrap-around: sum is modulo 2^WIDTH.
- Simultaneous accept and drain in the same cycle is legal and keeps full throughput.
- Arithmetic
  - All arithmetic is purely combinational inside a stage: group generate/propagate, then a group-carry lookahead across the SLICE/BLOCK groups.
  - No ripple across groups.
- STAGES=1 degenerates to a single registered CLA with latency 1.

Decomposition:
- Package cla_pkg:
  - function clog2
  - localparam derivation helpers (SLICE, NGROUPS)
  - typedef of the stage record: valid, partial sum, skewed a/b, carry, sub flag.
- Sub-module cla_group: combinational BLOCK-bit CLA. Inputs a, b, cin. Outputs sum, group generate G, group propagate P.
- pipelined_cla_adder instantiates NGROUPS cla_group per stage in a generate loop, with a lookahead unit over G/P.

Test Plan:
- Reset, then a=32'h00000001, b=32'h00000001, cin=0, sub=0 → 2 cycles later out_valid=1, sum=32'h00000002, cout=0, ovf=0, zero=0.
- a=32'hFFFFFFFF, b=32'h00000001 → sum=0, cout=1, zero=1, ovf=0. Then a=32'h7FFFFFFF, b=1 → sum=32'h80000000, ovf=1, cout=0.
- sub=1, a=5, b=7 → sum=32'hFFFFFFFE, cout=0 (borrow), ovf=0. Then sub=1, a=32'h80000000, b=1 → sum=32'h7FFFFFFF, ovf=1, cout=1.
- Stream 50 random beats with in_valid=1 and out_ready toggled pseudo-randomly → results match a scoreboard of a+b+cin in order. No drops or duplicates. in_ready low only when the pipe is full and stalled.
- Assert rst for 1 cycle while 2 beats are in flight → out_valid=0 on the next cycle, and those beats never emerge. A beat issued after reset emerges at latency STAGES.
- Re-run the scoreboard at WIDTH=64, STAGES=4, BLOCK=8 with a=64'hFFFFFFFFFFFFFFFF, b=1, cin=1 → sum=1, cout=1, latency 4.
